// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_arb_pkg
// Description : Shared types, default parameters and helpers for the
//               FIFO write-port burst arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

    localparam int DEF_D_WIDTH   = 8;
    localparam int DEF_N_REQ     = 4;
    localparam int DEF_MAX_BURST = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // burst_cnt must be able to hold 0..MAX_BURST
    function automatic int burst_cnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Scans req starting at ptr,
//               wrapping modulo N_REQ, and reports the first set index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] winner
);

    int w_j;

    // Scan from the farthest offset down so the nearest hit to ptr wins last
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        w_j    = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_j = int'(ptr) + k;
            if (w_j >= N_REQ) begin
                w_j = w_j - N_REQ;
            end
            if (req[w_j[IDX_W-1:0]]) begin
                valid  = 1'b1;
                winner = w_j[IDX_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin burst arbiter feeding one FIFO write port.
//               A winner keeps the port for up to MAX_BURST accepted words or
//               until it drops req; the next winner is granted on the same
//               edge the burst ends, with the old owner lowest priority.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int D_WIDTH   = DEF_D_WIDTH,
    parameter int N_REQ     = DEF_N_REQ,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                       wclk,
    input  logic                       wrst_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*D_WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]           gnt,
    input  logic                       wfull,
    output logic                       winc,
    output logic [D_WIDTH-1:0]         wdata,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   owner
);

    localparam int C_IDX_W = $clog2(N_REQ);
    localparam int C_CNT_W = burst_cnt_width(MAX_BURST);
    localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(MAX_BURST - 1);

    arb_state_t           r_state, w_state_nxt;
    logic [N_REQ-1:0]     r_gnt, w_gnt_nxt;
    logic [C_IDX_W-1:0]   r_owner, w_owner_nxt;
    logic [C_IDX_W-1:0]   r_ptr, w_ptr_nxt;
    logic [C_CNT_W-1:0]   r_cnt, w_cnt_nxt;

    logic                 w_owner_req;
    logic                 w_accept;
    logic                 w_burst_end;
    logic [C_IDX_W-1:0]   w_ptr_after;
    logic [N_REQ-1:0]     w_pick_req;
    logic [C_IDX_W-1:0]   w_pick_ptr;
    logic                 w_pick_valid;
    logic [C_IDX_W-1:0]   w_pick_idx;
    logic [D_WIDTH-1:0]   w_slice [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign w_slice[gi] = req_data[gi*D_WIDTH +: D_WIDTH];
        end
    endgenerate

    assign w_owner_req = |(r_gnt & req);
    assign w_accept    = w_owner_req & ~wfull;
    assign w_burst_end = (r_state == BURST) &
                         (~w_owner_req | (w_accept & (r_cnt == C_LAST)));
    assign w_ptr_after = (r_owner == C_IDX_W'(N_REQ - 1)) ? '0 : r_owner + 1'b1;

    // During a burst the picker looks ahead from owner+1 with the owner masked,
    // so the hand-over winner is ready on the ending edge
    assign w_pick_req  = (r_state == BURST) ? (req & ~r_gnt) : req;
    assign w_pick_ptr  = (r_state == BURST) ? w_ptr_after : r_ptr;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (C_IDX_W)
    ) u_rr_pick (
        .req    (w_pick_req),
        .ptr    (w_pick_ptr),
        .valid  (w_pick_valid),
        .winner (w_pick_idx)
    );

    assign gnt   = r_gnt;
    assign owner = r_owner;
    assign busy  = (r_state == BURST);
    assign winc  = w_accept;
    assign wdata = (|r_gnt) ? w_slice[r_owner] : '0;

    // Arbiter state register; reset discards any burst in progress
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state: grant from IDLE, count accepts, hand over or retire at burst end
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = BURST;
                    w_gnt_nxt   = N_REQ'(1) << w_pick_idx;
                    w_owner_nxt = w_pick_idx;
                    w_cnt_nxt   = '0;
                end
            end
            BURST: begin
                if (w_burst_end) begin
                    w_ptr_nxt = w_ptr_after;
                    w_cnt_nxt = '0;
                    if (w_pick_valid) begin
                        w_gnt_nxt   = N_REQ'(1) << w_pick_idx;
                        w_owner_nxt = w_pick_idx;
                    end else begin
                        w_state_nxt = IDLE;
                        w_gnt_nxt   = '0;
                        w_owner_nxt = '0;
                    end
                end else if (w_accept) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
                w_owner_nxt = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Scoreboard bench for fifo_wr_arbiter. Each issued word is
//               queued as an expected FIFO write; a negedge monitor pops the
//               owner's oldest entry on every winc and compares the data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    logic        wclk;
    logic        wrst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic        wfull;
    logic        winc;
    logic [7:0]  wdata;
    logic        busy;
    logic [1:0]  owner;

    fifo_wr_arbiter #(
        .D_WIDTH   (8),
        .N_REQ     (4),
        .MAX_BURST (4)
    ) dut (
        .wclk     (wclk),
        .wrst_n   (wrst_n),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .wfull    (wfull),
        .winc     (winc),
        .wdata    (wdata),
        .busy     (busy),
        .owner    (owner)
    );

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] src_mem [4][512];
    int         src_wr [4];
    int         src_rd [4];
    int         checks;
    int         errors;
    int         n_writes;
    bit         acc_valid;
    int         acc_id;

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Present each requester's oldest unsent word
    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            req[i]            = (src_rd[i] != src_wr[i]);
            req_data[i*8 +: 8] = req[i] ? src_mem[i][src_rd[i]] : 8'h00;
        end
    endtask

    // Queue n words for requester i and record them as expected writes
    task automatic issue(input int i, input int n);
        logic [7:0] d;
        logic [1:0] id2;
        id2 = 2'(i);
        for (int k = 0; k < n; k++) begin
            d = {id2, 6'($urandom)};
            src_mem[i][src_wr[i]] = d;
            src_wr[i]++;
            exp_q.push_back('{id: id2, data: d});
        end
        drive();
    endtask

    task automatic tick();
        @(posedge wclk);
        #2;
    endtask

    task automatic drain(input string name, input int budget);
        for (int c = 0; c < budget && (exp_q.size() != 0 || busy); c++) begin
            if (c == budget - 1) break;
            tick();
        end
        chk(name, {31'd0, (exp_q.size() == 0 && !busy)}, 32'd1);
    endtask

    // Monitor: every FIFO write must match the owner's oldest expected word
    always @(negedge wclk) begin
        if (winc) begin
            int idx;
            idx = -1;
            for (int k = 0; k < exp_q.size(); k++) begin
                if (idx < 0 && exp_q[k].id == owner) idx = k;
            end
            chk("gnt_onehot_owner", {31'd0, ($onehot(gnt) && gnt[owner])}, 32'd1);
            if (idx < 0) begin
                chk("unexpected_write", {24'd0, wdata}, 32'hFFFF_FFFF);
            end else begin
                chk("wdata", {24'd0, wdata}, {24'd0, exp_q[idx].data});
                exp_q.delete(idx);
            end
            n_writes++;
            acc_valid = 1'b1;
            acc_id    = int'(owner);
        end
    end

    // Source model: retire the word accepted on this edge, present the next
    always @(posedge wclk) begin
        #1;
        if (acc_valid) begin
            if (src_rd[acc_id] != src_wr[acc_id]) src_rd[acc_id]++;
            acc_valid = 1'b0;
        end
        drive();
    end

    initial begin
        int base;
        checks   = 0;
        errors   = 0;
        n_writes = 0;
        acc_valid = 1'b0;
        acc_id   = 0;
        for (int i = 0; i < 4; i++) begin
            src_wr[i] = 0;
            src_rd[i] = 0;
        end
        req      = '0;
        req_data = '0;
        wfull    = 1'b0;
        wrst_n   = 1'b0;

        // Reset held 5 cycles with all requesters pending
        for (int i = 0; i < 4; i++) issue(i, 1);
        for (int c = 0; c < 5; c++) begin
            tick();
            #1;
            chk("rst_gnt", {28'd0, gnt}, 32'h0);
            chk("rst_winc", {31'd0, winc}, 32'h0);
        end
        wrst_n = 1'b1;
        #1;
        chk("rel_gnt_latency", {28'd0, gnt}, 32'h0);
        chk("rel_winc_latency", {31'd0, winc}, 32'h0);
        tick();
        #1;
        chk("first_gnt", {28'd0, gnt}, 32'h1);
        chk("owner_after_rst", {30'd0, owner}, 32'h0);
        drain("drain_reset", 60);

        // Fairness: 8 words each, bursts of 4 back to back in order 0,1,2,3,0..
        for (int i = 0; i < 4; i++) issue(i, 8);
        for (int c = 0; c < 32; c++) begin
            tick();
            #1;
            chk("fair_owner", {29'd0, winc, owner}, {29'd0, 1'b1, 2'((c / 4) % 4)});
        end
        tick();
        #1;
        chk("fair_idle_gnt", {28'd0, gnt}, 32'h0);
        chk("fair_idle_busy", {31'd0, busy}, 32'h0);

        // Early release: requester 2 sends 2 words then drops req
        issue(2, 2);
        tick();
        #1;
        chk("early_gnt", {28'd0, gnt}, 32'h4);
        chk("early_w1", {31'd0, winc}, 32'h1);
        tick();
        #1;
        chk("early_w2", {31'd0, winc}, 32'h1);
        tick();
        #1;
        chk("early_drop_winc", {31'd0, winc}, 32'h0);
        chk("early_drop_busy", {31'd0, busy}, 32'h1);
        tick();
        #1;
        chk("early_end_gnt", {28'd0, gnt}, 32'h0);
        chk("early_end_busy", {31'd0, busy}, 32'h0);
        // ptr is now 3: of {2,3} requester 3 must win
        issue(2, 1);
        issue(3, 1);
        tick();
        #1;
        chk("ptr3_gnt", {28'd0, gnt}, 32'h8);
        drain("drain_ptr3", 40);
        issue(2, 1);
        tick();
        #1;
        chk("wrap_gnt2", {28'd0, gnt}, 32'h4);
        drain("drain_wrap", 40);

        // Backpressure: 6 full cycles after 2 words, then exactly 2 more
        issue(1, 8);
        tick();
        #1;
        chk("bp_gnt", {28'd0, gnt}, 32'h2);
        chk("bp_w1", {31'd0, winc}, 32'h1);
        tick();
        #1;
        chk("bp_w2", {31'd0, winc}, 32'h1);
        tick();
        wfull = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("bp_full_winc", {31'd0, winc}, 32'h0);
            chk("bp_full_gnt", {28'd0, gnt}, 32'h2);
            tick();
        end
        wfull = 1'b0;
        #1;
        chk("bp_w3", {31'd0, winc}, 32'h1);
        tick();
        #1;
        chk("bp_w4", {31'd0, winc}, 32'h1);
        tick();
        #1;
        chk("bp_end_gnt", {28'd0, gnt}, 32'h0);
        chk("bp_end_winc", {31'd0, winc}, 32'h0);
        drain("drain_bp", 60);

        // Data integrity: 64 random words each under random backpressure
        for (int i = 0; i < 4; i++) issue(i, 64);
        for (int c = 0; c < 3000 && exp_q.size() != 0; c++) begin
            wfull = ($urandom_range(0, 3) == 0);
            tick();
        end
        wfull = 1'b0;
        drain("drain_random", 60);

        // Mid-burst reset on the 3rd accepted word
        issue(2, 8);
        base = n_writes;
        for (int c = 0; c < 100 && (n_writes - base) < 3; c++) tick();
        chk("mrst_reach3", n_writes - base, 32'd3);
        wrst_n = 1'b0;
        #1;
        chk("mrst_gnt", {28'd0, gnt}, 32'h0);
        chk("mrst_busy", {31'd0, busy}, 32'h0);
        chk("mrst_winc", {31'd0, winc}, 32'h0);
        chk("mrst_wdata", {24'd0, wdata}, 32'h0);
        for (int i = 0; i < 4; i++) src_rd[i] = src_wr[i];
        exp_q.delete();
        issue(1, 1);
        issue(3, 1);
        tick();
        tick();
        #1;
        chk("mrst_hold_gnt", {28'd0, gnt}, 32'h0);
        wrst_n = 1'b1;
        tick();
        #1;
        chk("mrst_restart_gnt", {28'd0, gnt}, 32'h2);
        drain("drain_mrst", 40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
